// File: rtl/ni_injector_pkg.sv
// ni_injector_pkg: constants and types shared by the network-interface send
// stage and its payload FIFO.
//   TAM_FLIT - flit width in bits (header, size and payload flits alike)
//   state_t  - send-stage FSM state encoding
package ni_injector_pkg;

  localparam int TAM_FLIT = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_SIZE    = 2'd2,
    S_PAYLOAD = 2'd3
  } state_t;

endpackage

// File: rtl/ni_fifo.sv
// ni_fifo: synchronous payload buffer for the send stage.
// Ports:
//   clock, reset    - design clock, asynchronous active-low reset
//   push, data_in   - write request and word (ignored while full)
//   pop             - read request (ignored while empty)
//   full, empty     - occupancy flags decoded from the registered count
//   head            - oldest stored word, 0 when empty
// DEPTH must be a power of two so that the pointers wrap naturally.
module ni_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // No write-to-read bypass: a word pushed into an empty FIFO shows on head
  // only after it has been stored.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is data only and needs no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/ni_injector.sv
// ni_injector: network-interface send stage feeding a router Local port.
// Takes a packet descriptor (target, size) and a payload word stream and
// serialises them as header flit, size flit, then size payload flits, under
// credit flow control.
// Ports:
//   clock, reset                             - clock, asynchronous active-low reset
//   pkt_valid/pkt_ready/pkt_target/pkt_size  - descriptor handshake
//   payload_valid/payload_ready/payload_data - payload word handshake into FIFO
//   tx, data_out                             - flit toward router Local rx/data_in
//   credit_i                                 - router can take a flit this cycle
//   busy                                     - a packet is in progress
//   pkt_sent                                 - pulse the cycle after the last flit moves
// FIFO_DEPTH must be a power of two and at least 2.
module ni_injector
  import ni_injector_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pkt_valid,
  output logic                pkt_ready,
  input  logic [TAM_FLIT-1:0] pkt_target,
  input  logic [TAM_FLIT-1:0] pkt_size,
  input  logic                payload_valid,
  output logic                payload_ready,
  input  logic [TAM_FLIT-1:0] payload_data,
  output logic                tx,
  output logic [TAM_FLIT-1:0] data_out,
  input  logic                credit_i,
  output logic                busy,
  output logic                pkt_sent
);

  state_t              state;
  state_t              state_nxt;
  logic [TAM_FLIT-1:0] target_q;
  logic [TAM_FLIT-1:0] size_q;
  logic [TAM_FLIT-1:0] remaining;
  logic                fifo_full;
  logic                fifo_empty;
  logic [TAM_FLIT-1:0] fifo_head;
  logic                pop;
  logic                last_xfer;

  ni_fifo #(
    .WIDTH (TAM_FLIT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (payload_valid),
    .data_in (payload_data),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  assign payload_ready = !fifo_full;
  assign busy          = (state != S_IDLE);
  assign pop           = (state == S_PAYLOAD) && tx && credit_i;

  // Moore outputs and next state. credit_i only matters where tx is high.
  always_comb begin
    state_nxt = state;
    tx        = 1'b0;
    data_out  = '0;
    pkt_ready = 1'b0;
    last_xfer = 1'b0;
    case (state)
      S_IDLE: begin
        pkt_ready = 1'b1;
        if (pkt_valid) state_nxt = S_HEADER;
      end
      S_HEADER: begin
        tx       = 1'b1;
        data_out = target_q;
        if (credit_i) state_nxt = S_SIZE;
      end
      S_SIZE: begin
        tx       = 1'b1;
        data_out = size_q;
        if (credit_i) begin
          if (size_q == '0) begin
            state_nxt = S_IDLE;
            last_xfer = 1'b1;
          end else begin
            state_nxt = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        // Starved FIFO simply drops tx; head is 0 when empty.
        tx       = !fifo_empty;
        data_out = fifo_head;
        if (!fifo_empty && credit_i && remaining == TAM_FLIT'(1)) begin
          state_nxt = S_IDLE;
          last_xfer = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      pkt_sent  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pkt_sent <= last_xfer;
      if (state == S_SIZE && credit_i) remaining <= size_q;
      else if (pop)                    remaining <= remaining - 1'b1;
    end
  end

  // Descriptor capture; pkt_ready is only high in IDLE.
  always_ff @(posedge clock) begin
    if (pkt_valid && pkt_ready) begin
      target_q <= pkt_target;
      size_q   <= pkt_size;
    end
  end

endmodule

// File: tb/tb_ni_injector.sv
// tb_ni_injector: self-checking bench for ni_injector. The reference model
// treats each packet as the flit list {target, size, next size payload words
// in push order} and compares it with the flits seen crossing the Local port.
module tb_ni_injector;
  import ni_injector_pkg::*;

  localparam int W = TAM_FLIT;

  logic         clock = 1'b0;
  logic         reset;
  logic         pkt_valid;
  logic         pkt_ready;
  logic [W-1:0] pkt_target;
  logic [W-1:0] pkt_size;
  logic         payload_valid;
  logic         payload_ready;
  logic [W-1:0] payload_data;
  logic         tx;
  logic [W-1:0] data_out;
  logic         credit_i;
  logic         busy;
  logic         pkt_sent;

  int checks = 0;
  int passes = 0;

  // Stimulus / model state
  logic [W-1:0] push_q[$];     // words the core offers, in order (tasks append)
  int           push_idx = 0;  // words accepted so far (monitor owns)
  logic [W-1:0] model_pay[$];  // words accepted into the FIFO (monitor owns)
  int           pay_rd = 0;    // model payload words already assigned to packets
  logic [W-1:0] obs_q[$];      // flits seen transferring (monitor owns)
  int           obs_rd = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] dt_q[$];
  logic [W-1:0] ds_q[$];
  int           sent_cnt = 0;
  int           busy_cyc = 0;
  int           hold_err = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  int           credit_force = 1;   // <0 random, else constant level
  int           push_gap_max = 0;
  int           seen_idx = 0;
  int           push_hold = 0;

  ni_injector #(.FIFO_DEPTH(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .pkt_valid     (pkt_valid),
    .pkt_ready     (pkt_ready),
    .pkt_target    (pkt_target),
    .pkt_size      (pkt_size),
    .payload_valid (payload_valid),
    .payload_ready (payload_ready),
    .payload_data  (payload_data),
    .tx            (tx),
    .data_out      (data_out),
    .credit_i      (credit_i),
    .busy          (busy),
    .pkt_sent      (pkt_sent)
  );

  always #5 clock = ~clock;

  // Monitor: sampled mid-cycle, the values here are what the next edge acts on.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (prev_stall && (tx !== 1'b1 || data_out !== prev_data)) hold_err++;
      if (tx === 1'b1 && credit_i === 1'b1) obs_q.push_back(data_out);
      if (pkt_sent === 1'b1) sent_cnt++;
      if (busy === 1'b1) busy_cyc++;
      if (payload_valid === 1'b1 && payload_ready === 1'b1) begin
        model_pay.push_back(payload_data);
        push_idx++;
      end
      prev_stall = (tx === 1'b1 && credit_i === 1'b0);
      prev_data  = data_out;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Payload driver with optional random gaps after each accepted word.
  initial begin
    payload_valid = 1'b0;
    payload_data  = '0;
    forever begin
      @(posedge clock); #1;
      if (push_idx != seen_idx) begin
        seen_idx  = push_idx;
        push_hold = (push_gap_max > 0) ? int'($urandom_range(push_gap_max, 0)) : 0;
      end
      if (push_hold > 0) begin
        push_hold--;
        payload_valid = 1'b0;
      end else if (push_idx < push_q.size()) begin
        payload_valid = 1'b1;
        payload_data  = push_q[push_idx];
      end else begin
        payload_valid = 1'b0;
        payload_data  = '0;
      end
    end
  end

  // Credit driver.
  initial begin
    credit_i = 1'b1;
    forever begin
      @(posedge clock); #2;
      if (credit_force < 0) credit_i = ($urandom_range(3, 0) != 0);
      else                  credit_i = (credit_force != 0);
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic drive_desc(input logic [W-1:0] t, input logic [W-1:0] s);
    pkt_valid  = 1'b1;
    pkt_target = t;
    pkt_size   = s;
    dt_q.push_back(t);
    ds_q.push_back(s);
  endtask

  task automatic send_pkt(input logic [W-1:0] t, input logic [W-1:0] s);
    int cyc = 0;
    drive_desc(t, s);
    @(negedge clock);
    while (pkt_ready !== 1'b1 && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    tick();
    pkt_valid = 1'b0;
  endtask

  task automatic preload(input int n, output logic [W-1:0] first);
    int cyc = 0;
    first = '0;
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] w;
      w = W'($urandom);
      if (i == 0) first = w;
      push_q.push_back(w);
    end
    while (push_idx < push_q.size() && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic wait_sent(input int base, input int n);
    int cyc = 0;
    while (sent_cnt - base < n && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  // Reference: every accepted descriptor owns the next `size` pushed words.
  task automatic model_expected();
    exp_q.delete();
    while (dt_q.size() > 0) begin
      logic [W-1:0] t;
      logic [W-1:0] s;
      t = dt_q.pop_front();
      s = ds_q.pop_front();
      exp_q.push_back(t);
      exp_q.push_back(s);
      for (int i = 0; i < int'(s); i++) begin
        if (pay_rd < model_pay.size()) begin
          exp_q.push_back(model_pay[pay_rd]);
          pay_rd++;
        end else begin
          exp_q.push_back('x);
        end
      end
    end
  endtask

  function automatic int first_diff();
    int n = obs_q.size() - obs_rd;
    for (int i = 0; i < n && i < exp_q.size(); i++)
      if (obs_q[obs_rd + i] !== exp_q[i]) return i;
    if (n != exp_q.size()) return (n < exp_q.size()) ? n : exp_q.size();
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b0 || pkt_sent !== 1'b0 || data_out !== '0)
      $display("FAIL reset_outputs: tx=%b busy=%b pkt_sent=%b data_out=%h, want 0 0 0 0000",
               tx, busy, pkt_sent, data_out);
    else passes++;
    tick();
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (pkt_ready !== 1'b1 || payload_ready !== 1'b1)
      $display("FAIL reset_ready: pkt_ready=%b payload_ready=%b, want 1 1", pkt_ready, payload_ready);
    else passes++;
  endtask

  task automatic test_basic();
    logic [W-1:0] seq [4];
    logic [W-1:0] f;
    int s0, b0, d;
    seq[0] = 16'h0102; seq[1] = 16'h0002; seq[2] = 16'hAAAA; seq[3] = 16'hBBBB;
    credit_force = 1;
    push_q.push_back(16'hAAAA);
    push_q.push_back(16'hBBBB);
    preload(0, f);
    s0 = sent_cnt; b0 = busy_cyc;
    tick();
    drive_desc(16'h0102, 16'd2);
    @(negedge clock);
    checks++;
    if (pkt_ready !== 1'b1) $display("FAIL basic_ready: pkt_ready=%b, want 1", pkt_ready);
    else passes++;
    tick();
    pkt_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (tx !== 1'b1 || data_out !== seq[i])
        $display("FAIL basic_flit%0d: tx=%b data_out=%h, want 1 %h", i, tx, data_out, seq[i]);
      else passes++;
    end
    @(negedge clock);
    checks++;
    if (tx !== 1'b0 || pkt_sent !== 1'b1 || busy !== 1'b0)
      $display("FAIL basic_end: tx=%b pkt_sent=%b busy=%b, want 0 1 0", tx, pkt_sent, busy);
    else passes++;
    repeat (3) @(negedge clock);
    checks++;
    if (sent_cnt - s0 !== 1) $display("FAIL basic_sent_count: %0d pulses, want 1", sent_cnt - s0);
    else passes++;
    checks++;
    if (busy_cyc - b0 !== 4) $display("FAIL basic_busy_cycles: %0d, want 4", busy_cyc - b0);
    else passes++;
    model_expected();
    d = first_diff();
    checks++;
    if (d != -1) $display("FAIL basic_stream: %0d flits seen, %0d expected, first diff at %0d",
                          obs_q.size() - obs_rd, exp_q.size(), d);
    else passes++;
    obs_rd = obs_q.size();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] f;
    logic [W-1:0] e;
    int s0, b0, h0, d;
    credit_force = 1;
    push_q.push_back(16'hAAAA);
    push_q.push_back(16'hBBBB);
    preload(0, f);
    s0 = sent_cnt; b0 = busy_cyc; h0 = hold_err;
    tick();
    drive_desc(16'h0102, 16'd2);
    tick();
    pkt_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      credit_force = (c >= 2 && c <= 4) ? 0 : 1;
      e = (c == 1) ? 16'h0102 : (c <= 5) ? 16'h0002 : (c == 6) ? 16'hAAAA : 16'hBBBB;
      @(negedge clock);
      checks++;
      if (tx !== 1'b1 || data_out !== e)
        $display("FAIL bp_cycle%0d: tx=%b data_out=%h, want 1 %h", c, tx, data_out, e);
      else passes++;
      tick();
    end
    credit_force = 1;
    @(negedge clock);
    checks++;
    if (tx !== 1'b0 || pkt_sent !== 1'b1)
      $display("FAIL bp_end: tx=%b pkt_sent=%b, want 0 1", tx, pkt_sent);
    else passes++;
    checks++;
    if (busy_cyc - b0 !== 7 || hold_err != h0)
      $display("FAIL bp_length: busy %0d cycles, hold violations %0d, want 7 and 0",
               busy_cyc - b0, hold_err - h0);
    else passes++;
    wait_sent(s0, 1);
    model_expected();
    d = first_diff();
    checks++;
    if (d != -1) $display("FAIL bp_stream: %0d flits seen, %0d expected, first diff at %0d",
                          obs_q.size() - obs_rd, exp_q.size(), d);
    else passes++;
    obs_rd = obs_q.size();
  endtask

  task automatic test_zero_size();
    logic [W-1:0] w;
    int s0, d;
    credit_force = 1;
    preload(1, w);
    s0 = sent_cnt;
    tick();
    drive_desc(16'h0000, 16'h0000);
    tick();
    pkt_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock);
      checks++;
      if (tx !== 1'b1 || data_out !== 16'h0000)
        $display("FAIL zero_flit%0d: tx=%b data_out=%h, want 1 0000", c, tx, data_out);
      else passes++;
    end
    @(negedge clock);
    checks++;
    if (tx !== 1'b0 || pkt_sent !== 1'b1 || busy !== 1'b0)
      $display("FAIL zero_end: tx=%b pkt_sent=%b busy=%b, want 0 1 0", tx, pkt_sent, busy);
    else passes++;
    // The buffered word must still be there for the next packet.
    tick();
    send_pkt(W'($urandom), 16'd1);
    wait_sent(s0, 2);
    checks++;
    if (sent_cnt - s0 !== 2) $display("FAIL zero_sent: %0d packets, want 2", sent_cnt - s0);
    else passes++;
    model_expected();
    d = first_diff();
    checks++;
    if (d != -1 || obs_q[obs_q.size() - 1] !== w)
      $display("FAIL zero_stream: first diff at %0d, last flit %h, want word %h",
               d, obs_q[obs_q.size() - 1], w);
    else passes++;
    obs_rd = obs_q.size();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w0;
    logic [W-1:0] ta;
    logic [W-1:0] tb;
    int s0, d;
    credit_force = 1;
    preload(2, w0);
    ta = W'($urandom);
    tb = W'($urandom);
    s0 = sent_cnt;
    tick();
    drive_desc(ta, 16'd1);
    tick();
    drive_desc(tb, 16'd1);   // held valid while the first packet is in flight
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (tx !== 1'b1 || data_out !== w0)
      $display("FAIL b2b_payload: tx=%b data_out=%h, want 1 %h", tx, data_out, w0);
    else passes++;
    @(negedge clock);
    checks++;
    if (tx !== 1'b0 || pkt_sent !== 1'b1 || pkt_ready !== 1'b1)
      $display("FAIL b2b_gap: tx=%b pkt_sent=%b pkt_ready=%b, want 0 1 1", tx, pkt_sent, pkt_ready);
    else passes++;
    tick();
    pkt_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (tx !== 1'b1 || data_out !== tb)
      $display("FAIL b2b_header2: tx=%b data_out=%h, want 1 %h", tx, data_out, tb);
    else passes++;
    wait_sent(s0, 2);
    model_expected();
    d = first_diff();
    checks++;
    if (d != -1) $display("FAIL b2b_stream: %0d flits seen, %0d expected, first diff at %0d",
                          obs_q.size() - obs_rd, exp_q.size(), d);
    else passes++;
    obs_rd = obs_q.size();
  endtask

  task automatic test_fifo_full_wrap();
    logic [W-1:0] w;
    int s0, d;
    credit_force = 1;
    preload(8, w);
    @(negedge clock);
    checks++;
    if (payload_ready !== 1'b0 || model_pay.size() - pay_rd !== 8)
      $display("FAIL full_flag: payload_ready=%b buffered=%0d, want 0 8",
               payload_ready, model_pay.size() - pay_rd);
    else passes++;
    push_q.push_back(W'($urandom));
    push_q.push_back(W'($urandom));
    repeat (3) @(negedge clock);
    checks++;
    if (payload_ready !== 1'b0 || model_pay.size() - pay_rd !== 8)
      $display("FAIL full_hold: payload_ready=%b buffered=%0d, want 0 8",
               payload_ready, model_pay.size() - pay_rd);
    else passes++;
    s0 = sent_cnt;
    tick();
    send_pkt(W'($urandom), 16'd10);
    wait_sent(s0, 1);
    checks++;
    if (sent_cnt - s0 !== 1 || payload_ready !== 1'b1)
      $display("FAIL wrap_done: packets %0d payload_ready=%b, want 1 1", sent_cnt - s0, payload_ready);
    else passes++;
    model_expected();
    d = first_diff();
    checks++;
    if (d != -1) $display("FAIL wrap_stream: %0d flits seen, %0d expected, first diff at %0d",
                          obs_q.size() - obs_rd, exp_q.size(), d);
    else passes++;
    obs_rd = obs_q.size();
  endtask

  task automatic test_starvation();
    logic [W-1:0] w;
    int s0, d;
    credit_force = 1;
    preload(1, w);
    s0 = sent_cnt;
    tick();
    drive_desc(W'($urandom), 16'd3);
    tick();
    pkt_valid = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (tx !== 1'b1 || data_out !== w)
      $display("FAIL starve_first: tx=%b data_out=%h, want 1 %h", tx, data_out, w);
    else passes++;
    @(negedge clock);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1 || data_out !== '0)
      $display("FAIL starve_idle: tx=%b busy=%b data_out=%h, want 0 1 0000", tx, busy, data_out);
    else passes++;
    repeat (4) tick();
    push_q.push_back(W'($urandom));
    push_q.push_back(W'($urandom));
    wait_sent(s0, 1);
    checks++;
    if (sent_cnt - s0 !== 1 || obs_q.size() - obs_rd !== 5)
      $display("FAIL starve_done: packets %0d flits %0d at pulse, want 1 5",
               sent_cnt - s0, obs_q.size() - obs_rd);
    else passes++;
    model_expected();
    d = first_diff();
    checks++;
    if (d != -1) $display("FAIL starve_stream: %0d flits seen, %0d expected, first diff at %0d",
                          obs_q.size() - obs_rd, exp_q.size(), d);
    else passes++;
    obs_rd = obs_q.size();
  endtask

  task automatic test_random();
    int s0, d;
    credit_force = -1;
    push_gap_max = 2;
    s0 = sent_cnt;
    tick();
    for (int k = 0; k < 12; k++) begin
      int sz;
      sz = int'($urandom_range(10, 0));
      for (int i = 0; i < sz; i++) push_q.push_back(W'($urandom));
      send_pkt(W'($urandom), W'(sz));
    end
    wait_sent(s0, 12);
    credit_force = 1;
    push_gap_max = 0;
    checks++;
    if (sent_cnt - s0 !== 12) $display("FAIL rand_sent: %0d packets, want 12", sent_cnt - s0);
    else passes++;
    checks++;
    if (hold_err !== 0) $display("FAIL rand_hold: %0d stall cycles changed data_out, want 0", hold_err);
    else passes++;
    model_expected();
    d = first_diff();
    checks++;
    if (d != -1) $display("FAIL rand_stream: %0d flits seen, %0d expected, first diff at %0d",
                          obs_q.size() - obs_rd, exp_q.size(), d);
    else passes++;
    obs_rd = obs_q.size();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    int s0, d;
    credit_force = 1;
    preload(4, w);
    tick();
    drive_desc(W'($urandom), 16'd4);
    tick();
    pkt_valid = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b0 || busy !== 1'b0 || data_out !== '0)
      $display("FAIL midreset_async: tx=%b busy=%b data_out=%h, want 0 0 0000", tx, busy, data_out);
    else passes++;
    // The aborted packet and its leftover words are gone.
    dt_q.delete();
    ds_q.delete();
    @(posedge clock);
    #3 reset = 1'b1;
    pay_rd = model_pay.size();
    obs_rd = obs_q.size();
    @(negedge clock);
    checks++;
    if (pkt_ready !== 1'b1 || payload_ready !== 1'b1 || tx !== 1'b0)
      $display("FAIL midreset_release: pkt_ready=%b payload_ready=%b tx=%b, want 1 1 0",
               pkt_ready, payload_ready, tx);
    else passes++;
    preload(1, w);
    s0 = sent_cnt;
    tick();
    send_pkt(W'($urandom), 16'd1);
    wait_sent(s0, 1);
    checks++;
    if (sent_cnt - s0 !== 1) $display("FAIL midreset_sent: %0d packets, want 1", sent_cnt - s0);
    else passes++;
    model_expected();
    d = first_diff();
    checks++;
    if (d != -1) $display("FAIL midreset_stream: %0d flits seen, %0d expected, first diff at %0d",
                          obs_q.size() - obs_rd, exp_q.size(), d);
    else passes++;
    obs_rd = obs_q.size();
  endtask

  initial begin
    reset      = 1'b0;
    pkt_valid  = 1'b0;
    pkt_target = '0;
    pkt_size   = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_size();
    test_back_to_back();
    test_fifo_full_wrap();
    test_starvation();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
